// File: rtl/uart_frame_decoder.sv
// UART frame decoder: edge-detects the receiver strobe, parses SYNC/LEN/payload/CHK frames,
// and streams checksum-verified payloads out on a valid/ready interface.
module uart_frame_decoder #(
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int unsigned MAX_LEN      = 16,
  parameter int unsigned TIMEOUT_CLKS = 80000000
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Rx_DV,
  input  logic [7:0] Rx_Byte,
  output logic       Out_Valid,
  output logic [7:0] Out_Byte,
  output logic       Out_Last,
  input  logic       Out_Ready,
  output logic       Frame_Ok,
  output logic       Frame_Err,
  output logic [1:0] Err_Code,
  output logic [7:0] Drop_Count,
  output logic [2:0] Dbg_State
);

  // Handshake: a payload byte transfers on any rising Clk where Out_Valid & Out_Ready;
  // Out_Byte/Out_Last hold while Out_Valid & ~Out_Ready, and Out_Valid never drops without a transfer.

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [1:0] ERR_LEN     = 2'b01;
  localparam logic [1:0] ERR_CHK     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    LEN     = 3'd1,
    PAYLOAD = 3'd2,
    CHECK   = 3'd3,
    SEND    = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               dv_q;
  logic [IDX_W-1:0]   len_m1_q, len_m1_d;
  logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
  logic [IDX_W-1:0]   rd_nxt;
  logic [7:0]         sum_q, sum_d;
  logic [31:0]        idle_q, idle_d;
  logic               out_valid_q, out_valid_d;
  logic [7:0]         out_byte_q, out_byte_d;
  logic               out_last_q, out_last_d;
  logic               frame_ok_q, frame_ok_d;
  logic               frame_err_q, frame_err_d;
  logic [1:0]         err_code_q, err_code_d;
  logic [7:0]         drop_q, drop_d;
  logic [7:0]         pbuf_q [0:(1<<IDX_W)-1];
  logic               buf_we;
  logic               evt;
  logic               timeout;

  assign evt     = Rx_DV & ~dv_q;
  assign timeout = (idle_q == TIMEOUT_CLKS - 1);
  assign rd_nxt  = rd_idx_q + IDX_W'(1);

  always_comb begin
    state_d     = state_q;
    len_m1_d    = len_m1_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    sum_d       = sum_q;
    idle_d      = idle_q;
    out_valid_d = out_valid_q;
    out_byte_d  = out_byte_q;
    out_last_d  = out_last_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    drop_d      = drop_q;
    buf_we      = 1'b0;

    case (state_q)
      HUNT: begin
        if (evt && (Rx_Byte == SYNC_BYTE)) begin
          state_d = LEN;
          idle_d  = '0;
        end
      end

      LEN: begin
        if (evt) begin
          idle_d = '0;
          if ((Rx_Byte == 8'd0) || (32'(Rx_Byte) > MAX_LEN)) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_LEN;
            state_d     = HUNT;
          end else begin
            len_m1_d = IDX_W'(Rx_Byte - 8'd1);
            sum_d    = Rx_Byte;
            wr_idx_d = '0;
            state_d  = PAYLOAD;
          end
        end else if (timeout) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
          state_d     = HUNT;
        end else begin
          idle_d = idle_q + 32'd1;
        end
      end

      PAYLOAD: begin
        if (evt) begin
          idle_d   = '0;
          buf_we   = 1'b1;
          sum_d    = sum_q + Rx_Byte;
          wr_idx_d = wr_idx_q + IDX_W'(1);
          if (wr_idx_q == len_m1_q) state_d = CHECK;
        end else if (timeout) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
          state_d     = HUNT;
        end else begin
          idle_d = idle_q + 32'd1;
        end
      end

      CHECK: begin
        if (evt) begin
          idle_d = '0;
          if (Rx_Byte == sum_q) begin
            // First byte is presented together with Frame_Ok so it can transfer immediately.
            frame_ok_d  = 1'b1;
            rd_idx_d    = '0;
            out_valid_d = 1'b1;
            out_byte_d  = pbuf_q[0];
            out_last_d  = (len_m1_q == '0);
            state_d     = SEND;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CHK;
            state_d     = HUNT;
          end
        end else if (timeout) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
          state_d     = HUNT;
        end else begin
          idle_d = idle_q + 32'd1;
        end
      end

      SEND: begin
        if (evt && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
        if (out_valid_q && Out_Ready) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            state_d     = HUNT;
          end else begin
            rd_idx_d   = rd_nxt;
            out_byte_d = pbuf_q[rd_nxt];
            out_last_d = (rd_nxt == len_m1_q);
          end
        end
      end

      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= HUNT;
      dv_q        <= 1'b1;
      len_m1_q    <= '0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      sum_q       <= '0;
      idle_q      <= '0;
      out_valid_q <= 1'b0;
      out_byte_q  <= '0;
      out_last_q  <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= '0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      dv_q        <= Rx_DV;
      len_m1_q    <= len_m1_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      sum_q       <= sum_d;
      idle_q      <= idle_d;
      out_valid_q <= out_valid_d;
      out_byte_q  <= out_byte_d;
      out_last_q  <= out_last_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
      drop_q      <= drop_d;
    end
  end

  // Payload storage carries no reset: every entry is written before it is read.
  always_ff @(posedge Clk) begin
    if (buf_we) pbuf_q[wr_idx_q] <= Rx_Byte;
  end

  assign Out_Valid  = out_valid_q;
  assign Out_Byte   = out_byte_q;
  assign Out_Last   = out_last_q;
  assign Frame_Ok   = frame_ok_q;
  assign Frame_Err  = frame_err_q;
  assign Err_Code   = err_code_q;
  assign Drop_Count = drop_q;
  assign Dbg_State  = state_q;

endmodule

// File: doc/uart_frame_decoder.md
# uart_frame_decoder

Downstream consumer of the UART receiver. It turns the receiver's stretched byte-valid strobe into one byte event per received byte and parses the byte stream into framed packets: SYNC, LEN, LEN payload bytes, CHK. It buffers the payload and validates the checksum. Only checksum-verified payloads are released, on a valid/ready byte stream for the command logic.

## Interface
- `SYNC_BYTE`, default 8'hA5: frame start marker.
- `MAX_LEN`, default 16: largest legal LEN (1..255); sets payload buffer depth.
- `TIMEOUT_CLKS`, default 80000000: idle clocks allowed between bytes inside a frame (32-bit count).
- `Clk` input 1: single clock for all logic.
- `Rst_n` input 1: asynchronous, active-low reset.
- `Rx_DV` input 1: receiver Data_Valid. Level may stay high for many cycles per byte.
- `Rx_Byte` input 8: receiver byte, stable whenever `Rx_DV` is high.
- `Out_Valid` output 1: payload byte available.
- `Out_Byte` output 8: current payload byte.
- `Out_Last` output 1: `Out_Byte` is the final payload byte.
- `Out_Ready` input 1: consumer accepts `Out_Byte`.
- `Frame_Ok` output 1: one-cycle pulse when a frame passes checksum.
- `Frame_Err` output 1: one-cycle pulse when a frame is abandoned.
- `Err_Code` output 2: cause of the last error. 01 = bad length, 10 = checksum mismatch, 11 = timeout. Holds until the next error.
- `Drop_Count` output 8: saturating count of bytes discarded while streaming.

## Operation
- Byte event: `evt = Rx_DV & ~dv_q`, where `dv_q` is `Rx_DV` registered. `dv_q` resets to 1, so a strobe already high when reset releases is not counted. `Rx_Byte` is sampled on the `evt` cycle.
- States: HUNT, LEN, PAYLOAD, CHECK, SEND. Reset state is HUNT.
- HUNT:
  - `evt` with byte == `SYNC_BYTE` goes to LEN.
  - Any other byte is ignored silently.
- LEN:
  - `evt` with byte == 0 or byte > `MAX_LEN` raises Frame_Err with code 01 and returns to HUNT.
  - Otherwise store `len`, set `sum` = byte, clear the write index, and go to PAYLOAD.
- PAYLOAD:
  - Each `evt` writes `buf[idx]`, adds the byte to `sum`, and increments the index.
  - The event that writes index `len-1` moves to CHECK.
- CHECK:
  - `evt` with byte == `sum` raises Frame_Ok, clears the read index, and goes to SEND.
  - Otherwise it raises Frame_Err with code 10 and returns to HUNT.
- Checksum arithmetic: `sum` is 8 bits and wraps modulo 256. CHK = (LEN + Σpayload) mod 256.
- Timeout:
  - In LEN, PAYLOAD and CHECK, an idle counter clears on every `evt` and on entry from HUNT, and increments otherwise.
  - When it reaches `TIMEOUT_CLKS-1` without an `evt`, the block raises Frame_Err with code 11 and returns to HUNT.
  - An `evt` on that same cycle wins: it is processed normally and no timeout is raised.
- SEND:
  - `Out_Valid` = 1, `Out_Byte` = `buf[rd_idx]`, `Out_Last` = (`rd_idx == len-1`).
  - Transfer occurs when `Out_Valid & Out_Ready`; `rd_idx` then increments.
  - The transfer with `Out_Last` returns to HUNT.
- Drops:
  - An `evt` while in SEND is discarded and increments `Drop_Count`, which saturates at 255. This applies even on the final-transfer cycle.
  - A SYNC byte dropped this way is lost; no resynchronisation is attempted.
  - `Drop_Count` clears only on reset.
- Reset mid-operation, whether in a frame or in SEND: the frame is discarded and no pulse is emitted.
  - Outputs return to reset values: all 0, with `Drop_Count` = 0 and `Err_Code` = 00.

## Timing
- All outputs are registered.
- `Frame_Ok`/`Frame_Err` are high for exactly one cycle: the cycle after the clock edge at which the deciding `evt` or timeout is sampled.
- `Out_Valid` rises in the same cycle as `Frame_Ok`. The first payload byte can therefore transfer in that cycle if `Out_Ready` = 1.
- Sustained throughput is one byte per cycle with `Out_Ready` held high. `Out_Byte`/`Out_Last` stay stable while `Out_Valid & ~Out_Ready`.
- `Out_Valid` drops in the cycle after the last transfer. The block is in HUNT in that cycle and accepts a SYNC `evt` then.
- `Err_Code` updates in the same cycle `Frame_Err` pulses.
- Minimum byte spacing: one `evt` every 2 cycles. This is guaranteed by the receiver, whose strobes are much longer.

## Test plan
Bench parameters: `TIMEOUT_CLKS`=50, `MAX_LEN`=16, `Rx_DV` strobes of 4 cycles with 6-cycle gaps.
- Good frame, A5 03 11 22 33 69, with `Out_Ready`=1 → one Frame_Ok pulse, then `Out_Byte` 11, 22, 33 on consecutive cycles, with `Out_Last` only on 33.
- Garbage before sync, 00 FF A5 01 7F 80 → no Frame_Err, Frame_Ok, and a single byte 7F with `Out_Last`=1.
- Bad checksum, A5 02 10 20 00 → Frame_Err with `Err_Code`=10 and no `Out_Valid`. Then A5 01 05 06 → Frame_Ok.
- Bad length:
  - A5 00 → Frame_Err with code 01.
  - A5 11 → Frame_Err with code 01.
  - Any trailing bytes are ignored in HUNT.
- Timeout: A5 02 10 followed by silence → Frame_Err with code 11 exactly 50 cycles after the `evt` of 10. A subsequent good frame decodes correctly.
- Backpressure and drop:
  - Good 3-byte frame with `Out_Ready` held 0 for 30 cycles → `Out_Valid`=1 with `Out_Byte`=11 held stable.
  - A byte strobe during the stall increments `Drop_Count` to 1.
  - Releasing `Out_Ready` delivers 11, 22, 33.
  - Asserting `Rst_n`=0 mid-payload in a repeat run clears all outputs immediately.
